// File: rtl/serv_dbus_seq_pkg.sv
// -----------------------------------------------------------------------------
// serv_dbus_seq_pkg
// Shared definitions for the data-bus sequencer: Wishbone widths, the
// sequencer state encoding and a small address helper.
// -----------------------------------------------------------------------------
package serv_dbus_seq_pkg;

    localparam int WB_AW = 32;          // Wishbone address width
    localparam int WB_DW = 32;          // Wishbone data width
    localparam int WB_SW = WB_DW / 8;   // byte-lane select width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The bus is word addressed; lane selection carries the byte offset.
    function automatic logic [WB_AW-1:0] word_adr(input logic [WB_AW-1:0] adr);
        return {adr[WB_AW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/serv_dbus_wdog.sv
// -----------------------------------------------------------------------------
// serv_dbus_wdog
// Bus watchdog for the data-bus sequencer. Counts cycles while enabled and
// flags expiry on the cycle whose closing edge would bring the count to
// 2**TO_W-1. Only compiled when SERV_DBUS_TIMEOUT_EN is defined.
//
// Ports
//   i_clk     clock
//   i_rst     synchronous reset, active high
//   i_clr     clear counter to zero (held while the sequencer is idle)
//   i_en      count this cycle (sequencer waiting on the bus)
//   o_expire  combinational: this cycle is the last one before timeout
// -----------------------------------------------------------------------------
`ifdef SERV_DBUS_TIMEOUT_EN
module serv_dbus_wdog #(
    parameter int TO_W = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    assign cnt_d = cnt_q + TO_W'(1);

    // Expire when the increment about to happen reaches the limit, so the
    // sequencer leaves the bus on that same edge.
    assign o_expire = i_en && (cnt_d == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/serv_dbus_seq.sv
// -----------------------------------------------------------------------------
// serv_dbus_seq
// Data-bus transaction sequencer between the core load/store datapath and a
// single-beat Wishbone data port. One bus cycle per request; load data is
// captured and completion is reported with a one-cycle o_ack (+ o_err).
//
// Build option: define SERV_DBUS_TIMEOUT_EN to add a TO_W-bit bus watchdog
// that ends a stalled bus cycle with an error. Without it the sequencer waits
// on the bus indefinitely.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req                request (level, sampled only when idle)
//   i_we                 1 = store, 0 = load
//   i_adr, i_dat, i_sel  byte address, lane-aligned store data, lane enables
//   i_misalign           misaligned request: complete with error, no bus cycle
//   o_busy               sequencer not idle
//   o_ack, o_err         completion pulse and its error flag
//   o_rdt                last captured load data
//   o_wb_*               registered Wishbone master outputs (stb == cyc)
//   i_wb_rdt/ack/err     Wishbone slave response
// -----------------------------------------------------------------------------
module serv_dbus_seq
    import serv_dbus_seq_pkg::*;
#(
    parameter int TO_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_we,
    input  logic [WB_AW-1:0] i_adr,
    input  logic [WB_DW-1:0] i_dat,
    input  logic [WB_SW-1:0] i_sel,
    input  logic             i_misalign,
    output logic             o_busy,
    output logic             o_ack,
    output logic             o_err,
    output logic [WB_DW-1:0] o_rdt,
    output logic [WB_AW-1:0] o_wb_adr,
    output logic [WB_DW-1:0] o_wb_dat,
    output logic [WB_SW-1:0] o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    input  logic [WB_DW-1:0] i_wb_rdt,
    input  logic             i_wb_ack,
    input  logic             i_wb_err
);

    state_e           state_q;
    logic             ack_q;
    logic             err_q;
    logic [WB_DW-1:0] rdt_q;
    logic [WB_AW-1:0] adr_q;
    logic [WB_DW-1:0] dat_q;
    logic [WB_SW-1:0] sel_q;
    logic             we_q;
    logic             cyc_q;
    logic             wdog_expire;

`ifdef SERV_DBUS_TIMEOUT_EN
    // Held clear while idle so the count is zero on entry to the bus phase.
    serv_dbus_wdog #(
        .TO_W (TO_W)
    ) u_wdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (state_q == ST_IDLE),
        .i_en     (state_q == ST_BUS),
        .o_expire (wdog_expire)
    );
`else
    // TO_W only sizes the watchdog, which is not built here.
    logic unused_to_w;
    assign unused_to_w = (TO_W != 0);
    assign wdog_expire = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_req) begin
                        if (i_misalign) begin
                            state_q <= ST_DONE;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_BUS;
                            cyc_q   <= 1'b1;
                            adr_q   <= word_adr(i_adr);
                            dat_q   <= i_dat;
                            sel_q   <= i_sel;
                            we_q    <= i_we;
                        end
                    end
                end
                ST_BUS: begin
                    // ack has priority over err and over watchdog expiry.
                    if (i_wb_ack) begin
                        state_q <= ST_DONE;
                        cyc_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        if (!we_q) begin
                            rdt_q <= i_wb_rdt;
                        end
                    end else if (i_wb_err || wdog_expire) begin
                        state_q <= ST_DONE;
                        cyc_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Request is not looked at here, so a request still held
                    // during the completion cycle cannot start a second access.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = (state_q != ST_IDLE);
    assign o_ack    = ack_q;
    assign o_err    = err_q;
    assign o_rdt    = rdt_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;
    assign o_wb_we  = we_q;
    assign o_wb_cyc = cyc_q;

endmodule
